sum_splitter: RTL and testbench

- Inverse of the frame accumulator: takes one accumulated sum per pulse and emits DATA_LENGTH consecutive data-enabled beats whose values add back up to that sum.
- Per-beat value is floor(S/N); the remainder is spread over the first beats.
- Sits downstream of accumulator-style producers, wherever per-pixel or per-cell values must be re-expanded from a block total (e.g. normalisation write-back).

---
 rtl/sum_splitter_pkg.sv | 21 ++
 rtl/sum_splitter_div.sv | 66 ++++++
 rtl/sum_splitter.sv | 159 +++++++++++++++
 tb/tb_sum_splitter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_splitter_pkg.sv
// Shared types and helpers for the sum splitter.
// Build option: SUM_SPLITTER_REMAINDER_EN spreads the remainder over the first beats.
package sum_splitter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    EMIT
  } state_t;

  localparam int DEF_INPUT_WIDTH = 40;
  localparam int DIV_ITERS = DEF_INPUT_WIDTH;

  function automatic logic exceeds(
    input logic [63:0] v,
    input int unsigned w
  );
    return (v >> w) != 64'd0;
  endfunction

endpackage

// File: rtl/sum_splitter_div.sv
// Sequential restoring divider by a constant.
// Start performs the first step; the result is ready IW cycles after start.
module sum_splitter_div #(
  parameter int IW = 40,
  parameter int DIVISOR = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] dividend,
  output logic          done,
  output logic [IW-1:0] quotient,
  output logic [IW-1:0] remainder
);

  localparam int CW = $clog2(IW + 1);
  localparam logic [IW:0] D = (IW + 1)'(DIVISOR);

  logic [IW-1:0] rem;
  logic [IW-1:0] qd;
  logic [IW-1:0] rem_src;
  logic [IW-1:0] qd_src;
  logic [IW-1:0] rem_nx;
  logic [IW-1:0] qd_nx;
  logic [IW:0]   trial;
  logic          ge;
  logic [CW-1:0] cnt;
  logic          run;

  always_comb begin
    rem_src = start ? '0 : rem;
    qd_src  = start ? dividend : qd;
    trial   = {rem_src, qd_src[IW-1]};
    ge      = trial >= D;
    rem_nx  = ge ? IW'(trial - D) : trial[IW-1:0];
    qd_nx   = {qd_src[IW-2:0], ge};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem  <= '0;
      qd   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= rem_nx;
      qd   <= qd_nx;
      cnt  <= CW'(1);
      run  <= (IW > 1);
      done <= (IW == 1);
    end else if (run) begin
      rem  <= rem_nx;
      qd   <= qd_nx;
      cnt  <= cnt + CW'(1);
      run  <= (cnt != CW'(IW - 1));
      done <= (cnt == CW'(IW - 1));
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient  = qd;
  assign remainder = rem;

endmodule

// File: rtl/sum_splitter.sv
// Re-expands one accumulated sum into DATA_LENGTH beats.
// Build option: SUM_SPLITTER_REMAINDER_EN (undefined: truncating split).
module sum_splitter
  import sum_splitter_pkg::*;
#(
  parameter int INPUT_WIDTH    = DIV_ITERS,
  parameter int OUTPUT_WIDTH   = 36,
  parameter int DATA_LENGTH    = 9,
  parameter int COUNTER_LENGTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INPUT_WIDTH-1:0]    valueIn,
  input  logic                      deIn,
  output logic [OUTPUT_WIDTH-1:0]   valueOut,
  output logic                      deOut,
  output logic [COUNTER_LENGTH-1:0] counterOut,
  output logic                      busy,
  output logic                      overflow,
  output logic                      saturated
);

  localparam int IW = INPUT_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam int CL = COUNTER_LENGTH;

  state_t        state;
  logic [IW-1:0] slot;
  logic          slot_full;
  logic [IW-1:0] stage;
  logic          launch;

  logic          div_start;
  logic [IW-1:0] div_dividend;
  logic          div_done;
  logic [IW-1:0] div_q;
  logic [IW-1:0] div_r;

  logic          last;
  logic [CL-1:0] nk;
  logic          extra;
  logic [IW:0]   beat_v;
  logic          over;
  logic [OW-1:0] beat_o;

  assign last = (state == EMIT) && (counterOut == CL'(DATA_LENGTH));

  // Slot contents launch one cycle after the last beat.
  assign div_start = (state == IDLE && deIn) || launch
                   || (last && !slot_full && deIn);
  assign div_dividend = launch ? stage : valueIn;

  sum_splitter_div #(
    .IW     (IW),
    .DIVISOR(DATA_LENGTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .done     (div_done),
    .quotient (div_q),
    .remainder(div_r)
  );

  always_comb begin
    nk = (state == EMIT) ? counterOut + CL'(1) : CL'(1);
`ifdef SUM_SPLITTER_REMAINDER_EN
    extra = (IW'(nk) <= div_r);
`else
    extra = 1'b0;
`endif
    beat_v = {1'b0, div_q} + {{IW{1'b0}}, extra};
    over   = exceeds(64'(beat_v), OW);
    beat_o = over ? '1 : beat_v[OW-1:0];
  end

`ifndef SUM_SPLITTER_REMAINDER_EN
  logic unused_rem;
  assign unused_rem = ^div_r;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      slot       <= '0;
      slot_full  <= 1'b0;
      stage      <= '0;
      launch     <= 1'b0;
      valueOut   <= '0;
      deOut      <= 1'b0;
      counterOut <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      launch <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= deIn;
          if (deIn) state <= DIV;
        end
        DIV: begin
          busy <= 1'b1;
          if (deIn) begin
            if (!slot_full) begin
              slot      <= valueIn;
              slot_full <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          if (div_done) begin
            state      <= EMIT;
            deOut      <= 1'b1;
            counterOut <= nk;
            valueOut   <= beat_o;
            if (over) saturated <= 1'b1;
          end
        end
        EMIT: begin
          if (!last) begin
            busy       <= 1'b1;
            deOut      <= 1'b1;
            counterOut <= nk;
            valueOut   <= beat_o;
            if (over) saturated <= 1'b1;
            if (deIn) begin
              if (!slot_full) begin
                slot      <= valueIn;
                slot_full <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end else begin
            deOut      <= 1'b0;
            counterOut <= '0;
            valueOut   <= '0;
            busy       <= slot_full | deIn;
            if (slot_full) begin
              stage     <= slot;
              launch    <= 1'b1;
              state     <= DIV;
              slot_full <= deIn;
              if (deIn) slot <= valueIn;
            end else if (deIn) begin
              state <= DIV;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_splitter.sv
// Scoreboard bench for sum_splitter at default parameters.
// Expected beats come from a reference model of floor/remainder splitting.
module tb_sum_splitter;

  localparam int IW = 40;
  localparam int OW = 36;
  localparam int N  = 9;
  localparam int CL = 4;
`ifdef SUM_SPLITTER_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif
  localparam longint unsigned MAXO = (64'd1 << OW) - 64'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [IW-1:0] valueIn = '0;
  logic          deIn = 1'b0;
  logic [OW-1:0] valueOut;
  logic          deOut;
  logic [CL-1:0] counterOut;
  logic          busy;
  logic          overflow;
  logic          saturated;

  sum_splitter dut (
    .clk       (clk),
    .reset     (reset),
    .valueIn   (valueIn),
    .deIn      (deIn),
    .valueOut  (valueOut),
    .deOut     (deOut),
    .counterOut(counterOut),
    .busy      (busy),
    .overflow  (overflow),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned v;
    int k;
    int at;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  longint unsigned obs_sum;

  function automatic longint unsigned model(longint unsigned s, int k);
    longint unsigned q, r, v;
    q = s / N;
    r = s % N;
    v = q + ((REM_EN && longint'(k) <= r) ? 64'd1 : 64'd0);
    if (v > MAXO) v = MAXO;
    return v;
  endfunction

  task automatic push_frame(input longint unsigned s, input int c0);
    for (int k = 1; k <= N; k++) begin
      beat_t e;
      e.v  = model(s, k);
      e.k  = k;
      e.at = c0 + 40 + k;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic send(input longint unsigned s);
    logic [63:0] sv;
    sv = s;
    valueIn = sv[IW-1:0];
    deIn = 1'b1;
    tick();
    deIn = 1'b0;
    valueIn = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    tick();
  endtask

  // Pops one expectation per observed beat; idle cycles must read zero.
  task automatic drain(input int budget);
    int n;
    beat_t e;
    logic [63:0] ev;
    int ek;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (deOut) begin
        e = exp_q.pop_front();
        ev = e.v;
        ek = e.k;
        n_cmp++;
        if (valueOut !== ev[OW-1:0] || counterOut !== ek[CL-1:0]
            || cyc !== e.at) begin
          n_bad++;
          $display("FAIL beat: got value=%h counter=%0d cycle=%0d, want value=%h counter=%0d cycle=%0d",
                   valueOut, counterOut, cyc, ev[OW-1:0], ek, e.at);
        end
        obs_sum += valueOut;
      end else begin
        n_cmp++;
        if (valueOut !== '0 || counterOut !== '0) begin
          n_bad++;
          $display("FAIL idle_outputs: got value=%h counter=%0d, want 0/0",
                   valueOut, counterOut);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout: got %0d beats outstanding, want 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({valueOut, deOut, counterOut, busy, overflow, saturated} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h, want 0",
               {valueOut, deOut, counterOut, busy, overflow, saturated});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int c0;
    c0 = cyc;
    push_frame(90, c0);
    send(90);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_running: got %b, want 1", busy);
    end
    drain(80);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || deOut !== 1'b0 || cyc !== c0 + 50) begin
      n_bad++;
      $display("FAIL busy_drop: got busy=%b de=%b cycle=%0d, want 0/0/%0d",
               busy, deOut, cyc, c0 + 50);
    end
    tick();
  endtask

  task automatic test_remainder();
    longint unsigned want;
    obs_sum = 0;
    push_frame(94, cyc);
    send(94);
    drain(80);
    want = REM_EN ? 64'd94 : 64'd90;
    n_cmp++;
    if (obs_sum !== want) begin
      n_bad++;
      $display("FAIL sum94: got %0d, want %0d", obs_sum, want);
    end
    tick();
  endtask

  task automatic test_small();
    push_frame(5, cyc);
    send(5);
    drain(80);
    tick();
    obs_sum = 0;
    push_frame(0, cyc);
    send(0);
    drain(80);
    n_cmp++;
    if (obs_sum !== 64'd0) begin
      n_bad++;
      $display("FAIL sum0: got %0d, want 0", obs_sum);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    int seen;
    do_reset();
    c0 = cyc;
    push_frame(64'd1000, c0);
    push_frame(64'd2003, c0 + 50);
    send(64'd1000);
    wait_cyc(c0 + 10);
    send(64'd2003);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_early: got %b, want 0", overflow);
    end
    wait_cyc(c0 + 20);
    send(64'd777);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_set: got %b, want 1", overflow);
    end
    drain(200);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (deOut) seen++;
    end
    n_cmp++;
    if (seen !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL dropped_frame: got beats=%0d busy=%b, want 0/0",
               seen, busy);
    end
    tick();
  endtask

  task automatic test_refill();
    int c0;
    do_reset();
    c0 = cyc;
    push_frame(64'd45, c0);
    push_frame(64'd46, c0 + 50);
    push_frame(64'd47, c0 + 100);
    send(64'd45);
    wait_cyc(c0 + 10);
    send(64'd46);
    fork
      begin
        wait_cyc(c0 + 49);
        send(64'd47);
      end
      begin
        drain(300);
      end
    join
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL refill_overflow: got %b, want 0", overflow);
    end
    tick();
  endtask

  task automatic test_bypass();
    int c0;
    do_reset();
    c0 = cyc;
    push_frame(64'd18, c0);
    push_frame(64'd27, c0 + 49);
    send(64'd18);
    fork
      begin
        wait_cyc(c0 + 49);
        send(64'd27);
      end
      begin
        drain(200);
      end
    join
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    n_cmp++;
    if (saturated !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_clear: got %b, want 0", saturated);
    end
    push_frame((64'd1 << IW) - 64'd1, cyc);
    send((64'd1 << IW) - 64'd1);
    drain(80);
    n_cmp++;
    if (saturated !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_set: got %b, want 1", saturated);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int c0;
    int seen;
    do_reset();
    c0 = cyc;
    send(64'd90);
    wait_cyc(c0 + 44);
    n_cmp++;
    if (deOut !== 1'b1 || counterOut !== 4'd4) begin
      n_bad++;
      $display("FAIL pre_abort: got de=%b counter=%0d, want 1/4",
               deOut, counterOut);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (deOut !== 1'b0 || valueOut !== '0 || counterOut !== '0
        || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: got de=%b value=%h counter=%0d busy=%b, want 0",
               deOut, valueOut, counterOut, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (deOut) seen++;
    end
    n_cmp++;
    if (seen !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_abort: got beats=%0d busy=%b, want 0/0",
               seen, busy);
    end
    tick();
    push_frame(64'd123, cyc);
    send(64'd123);
    drain(80);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_remainder();
    test_small();
    test_back_to_back();
    test_refill();
    test_bypass();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
